multi_cycle_ctrl: RTL
=====================

Name: multi_cycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle control decoder: decodes the same MIPS subset (add, sub, ori, lw, sw, beq, lui, jal, jr) and sequences each instruction over several clocks with an FSM.
- Drives datapath selects and enables, and runs a request/ready handshake with the unified instruction/data memory.
- Adds a parametrised memory-wait timeout and a per-instruction completion pulse.
- Sits between the instruction register (IR) and the shared multi-cycle datapath.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles memReq may stay unanswered; 0 disables the timeout.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- opCode  in  6  IR[31:26]; stable from DECODE onward.
- func  in  6  IR[5:0].
- zero  in  1  ALU equality flag, valid in EXEC.
- memReady  in  1  memory completes the current request this cycle.
- memReq  out  1  memory request (fetch or data access).
- memWriteEn  out  1  data write; valid only together with memReq.
- irWriteEn  out  1  load IR from memory read data.
- pcWriteEn  out  1  update PC.
- pcSrcOp  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = register rs.
- regWriteEn  out  1  GRF write.
- aluOp  out  3  0 = add, 1 = sub, 3 = or.
- extOp  out  1  1 = sign extend, 0 = zero extend.
- aluInOp  out  2  1 = register rt, 0 = extended immediate.
- grfWriteOp  out  2  0 = memory, 1 = ALU, 2 = lui, 3 = PC+4.
- grfWriteAddrOp  out  2  0 = rt, 1 = rd, 2 = register 31.
- instrDone  out  1  one-cycle pulse in the last cycle of each instruction.
- busErr  out  1  sticky memory-timeout flag.
- state  out  3  current FSM state, for debug.

Behaviour:
- States: BOOT = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 7.
- Reset (resetN low, asynchronous): state = BOOT, wait counter = 0, busErr = 0. Every output is 0 in BOOT. BOOT moves to FETCH on the next clk.
- All outputs are combinational functions of the state register and of opCode/func. No output is asserted outside the state listed below.
- FETCH:
  - memReq = 1, pcSrcOp = 0.
  - When memReady = 1: irWriteEn = 1 and pcWriteEn = 1 (PC <= PC+4), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - jal: regWriteEn = 1, grfWriteAddrOp = 2, grfWriteOp = 3, pcWriteEn = 1, pcSrcOp = 2, instrDone = 1, then FETCH.
  - jr: pcWriteEn = 1, pcSrcOp = 3, instrDone = 1, then FETCH.
  - Any other decoded instruction goes to EXEC. Unknown opcodes are handled by the Optional Feature.
- EXEC:
  - aluOp and aluInOp follow the single-cycle encoding. extOp = 1 for lw, sw and beq.
  - beq: aluOp = 1, pcSrcOp = 1, pcWriteEn = zero, instrDone = 1, then FETCH.
  - lw and sw go to MEM. add, sub, ori and lui go to WB.
- MEM:
  - memReq = 1; memWriteEn = 1 for sw.
  - On memReady: sw pulses instrDone and goes to FETCH; lw goes to WB.
  - Otherwise stay in MEM.
- WB:
  - regWriteEn = 1 and instrDone = 1, then FETCH.
  - grfWriteOp: 1 for add/sub/ori, 2 for lui, 0 for lw.
  - grfWriteAddrOp: 1 for add/sub, 0 otherwise.
- Latency with zero-wait memory (memReady already high when memReq rises), counted FETCH to instrDone inclusive: jal/jr 2, beq 3, add/sub/ori/lui/sw 4, lw 5.
- Wait counter:
  - Cleared on entry to FETCH or MEM and whenever memReady = 1.
  - Increments each cycle memReq = 1 and memReady = 0.
  - If MEM_TIMEOUT > 0 and the counter equals MEM_TIMEOUT-1 while memReady = 0: next state HALT and busErr <= 1.
- memReady in the same cycle the counter reaches MEM_TIMEOUT-1 means success; ready wins.
- HALT: all outputs 0 except busErr and any trap flag. It is left only by reset.
- memReady is ignored in states that do not drive memReq.

Optional Feature:
- Macro: MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN.
- With the macro defined:
  - An unrecognised opcode/func in DECODE goes to HALT.
  - Adds output port illegalInstr (out, 1 bit, sticky), set in that cycle and cleared only by reset.
- Without the macro: an unrecognised instruction is a nop. DECODE pulses instrDone, goes to FETCH and writes no register. PC is already advanced. The illegalInstr port is absent.

Test Plan:
- Reset mid-MEM of an lw (resetN low for 1 cycle) -> state = 0 immediately, all outputs 0, busErr = 0; FETCH follows one clk after release.
- add (opCode 0x00, func 0x20), memReady tied 1 -> states 1, 2, 3, 5; instrDone on cycle 4; regWriteEn = 1, grfWriteAddrOp = 1, grfWriteOp = 1 in WB.
- beq (0x04) with zero = 1, then with zero = 0 -> pcWriteEn = 1 / 0 with pcSrcOp = 1 in EXEC; instrDone on cycle 3 in both cases.
- lw (0x23) with memReady delayed 3 cycles in MEM -> MEM held 4 cycles with memReq = 1 and memWriteEn = 0, then WB with grfWriteOp = 0 and regWriteEn = 1.
- MEM_TIMEOUT = 4, memReady held 0 in FETCH -> HALT after 4 FETCH cycles with busErr = 1; ready arriving on the 4th cycle instead -> DECODE and busErr = 0.
- opCode 0x3F: macro defined -> HALT with illegalInstr = 1; macro undefined -> instrDone in DECODE, regWriteEn never asserted, next state FETCH.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the MIPS subset (add, sub, ori, lw, sw, beq, lui, jal, jr).
// Define MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN to trap unknown instructions into HALT with a sticky illegalInstr flag.
module multi_cycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [5:0] opCode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWriteEn,
  output logic       irWriteEn,
  output logic       pcWriteEn,
  output logic [1:0] pcSrcOp,
  output logic       regWriteEn,
  output logic [2:0] aluOp,
  output logic       extOp,
  output logic [1:0] aluInOp,
  output logic [1:0] grfWriteOp,
  output logic [1:0] grfWriteAddrOp,
  output logic       instrDone,
  output logic       busErr,
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
  output logic       illegalInstr,
`endif
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_JR, I_ILL
  } instr_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  instr_e           instr;
  logic             timeout_hit;
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
  logic             ill_q, ill_d;
`endif

  always_comb begin
    instr = I_ILL;
    case (opCode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  instr = I_ADD;
          FN_SUB:  instr = I_SUB;
          FN_JR:   instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      OP_JAL:  instr = I_JAL;
      OP_BEQ:  instr = I_BEQ;
      OP_ORI:  instr = I_ORI;
      OP_LUI:  instr = I_LUI;
      OP_LW:   instr = I_LW;
      OP_SW:   instr = I_SW;
      default: instr = I_ILL;
    endcase
  end

  // The last allowed wait cycle; a ready in this very cycle still counts as success.
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    cnt_d          = '0;
    bus_err_d      = bus_err_q;
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
    ill_d          = ill_q;
`endif
    memReq         = 1'b0;
    memWriteEn     = 1'b0;
    irWriteEn      = 1'b0;
    pcWriteEn      = 1'b0;
    pcSrcOp        = 2'd0;
    regWriteEn     = 1'b0;
    aluOp          = 3'd0;
    extOp          = 1'b0;
    aluInOp        = 2'd0;
    grfWriteOp     = 2'd0;
    grfWriteAddrOp = 2'd0;
    instrDone      = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        memReq = 1'b1;
        if (memReady) begin
          irWriteEn = 1'b1;
          pcWriteEn = 1'b1;
          state_d   = ST_DECODE;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DECODE: begin
        case (instr)
          I_JAL: begin
            regWriteEn     = 1'b1;
            grfWriteAddrOp = 2'd2;
            grfWriteOp     = 2'd3;
            pcWriteEn      = 1'b1;
            pcSrcOp        = 2'd2;
            instrDone      = 1'b1;
            state_d        = ST_FETCH;
          end
          I_JR: begin
            pcWriteEn = 1'b1;
            pcSrcOp   = 2'd3;
            instrDone = 1'b1;
            state_d   = ST_FETCH;
          end
          I_ILL: begin
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
            ill_d     = 1'b1;
            state_d   = ST_HALT;
`else
            // Treated as a nop: PC already advanced in FETCH, nothing else to do.
            instrDone = 1'b1;
            state_d   = ST_FETCH;
`endif
          end
          default: state_d = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        aluOp   = (instr == I_SUB || instr == I_BEQ) ? 3'd1 :
                  (instr == I_ORI)                   ? 3'd3 : 3'd0;
        aluInOp = (instr == I_ADD || instr == I_SUB || instr == I_BEQ) ? 2'd1 : 2'd0;
        extOp   = (instr == I_LW || instr == I_SW || instr == I_BEQ);
        case (instr)
          I_BEQ: begin
            pcSrcOp   = 2'd1;
            pcWriteEn = zero;
            instrDone = 1'b1;
            state_d   = ST_FETCH;
          end
          I_LW, I_SW: state_d = ST_MEM;
          default:    state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        memReq     = 1'b1;
        memWriteEn = (instr == I_SW);
        if (memReady) begin
          if (instr == I_SW) begin
            instrDone = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d   = ST_WB;
          end
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WB: begin
        regWriteEn     = 1'b1;
        instrDone      = 1'b1;
        grfWriteOp     = (instr == I_LUI) ? 2'd2 :
                         (instr == I_LW)  ? 2'd0 : 2'd1;
        grfWriteAddrOp = (instr == I_ADD || instr == I_SUB) ? 2'd1 : 2'd0;
        state_d        = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_BOOT;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ill_q <= 1'b0;
    else         ill_q <= ill_d;
  end

  assign illegalInstr = ill_q;
`endif

  assign busErr = bus_err_q;
  assign state  = state_q;

endmodule
